// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-client 4-phase handshake arbiter.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int PTR_W   = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GNT,
    S_REQ,
    S_ACK,
    S_RTZ,
    S_DONE
  } arb_state_e;

  // First set request scanning ptr, ptr+1, ... (mod NUM_REQ); returns ptr when none set.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [PTR_W-1:0]   ptr);
    logic [PTR_W-1:0] idx;
    rr_pick = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ptr + PTR_W'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [NUM_REQ-1:0] idx2oh(input logic [PTR_W-1:0] idx);
    idx2oh      = '0;
    idx2oh[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level, cleared by reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/hs_arbiter4.sv
// Round-robin arbiter granting one of four 4-phase clients access to a shared
// 4-phase resource whose acknowledge arrives asynchronously.
module hs_arbiter4
  import arb_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] ack_o,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               req_out_o,
  input  logic               ack_in_i,
  output logic               busy_o
);

  logic ack_sync;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (ack_in_i),
    .q_o    (ack_sync)
  );

  arb_state_e         state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               req_out_q, req_out_d;
  logic               busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    case (state_q)
      S_IDLE: if (|req_i) begin
        owner_d = rr_pick(req_i, ptr_q);
        state_d = S_GNT;
      end
      S_GNT:  state_d = S_REQ;
      S_REQ:  if (ack_sync) state_d = S_ACK;
      S_ACK:  if (!req_i[owner_q]) state_d = S_RTZ;
      S_RTZ:  if (!ack_sync) state_d = S_DONE;
      S_DONE: begin
        ptr_d   = owner_q + 2'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so every output is a flop.
    gnt_d     = (state_d != S_IDLE) ? idx2oh(owner_d) : '0;
    ack_d     = (state_d inside {S_ACK, S_RTZ}) ? idx2oh(owner_d) : '0;
    req_out_d = state_d inside {S_REQ, S_ACK};
    busy_d    = state_d != S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      req_out_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      req_out_q <= req_out_d;
      busy_q    <= busy_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign ack_o     = ack_q;
  assign req_out_o = req_out_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_hs_arbiter4.sv
// Self-checking bench for hs_arbiter4: vector table, corner sequences, random clients.
module tb_hs_arbiter4;

  localparam int SYNC = 2;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [3:0] req_i = 4'b0;
  logic [3:0] ack_o, gnt_o;
  logic       req_out_o, busy_o;
  logic       ack_in_i;

  int checks = 0;
  int errors = 0;
  int resp_delay = 0;
  int model_ptr = 0;
  int model_owner = -1;
  logic [3:0] gq[$];

  typedef struct {
    logic [3:0] pat;
    logic [3:0] exp_gnt;
    int         dly;
  } vec_t;
  vec_t tbl[11];
  logic [3:0] cont_exp[5];

  hs_arbiter4 #(.SYNC_STAGES(SYNC)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_i),
    .ack_o     (ack_o),
    .gnt_o     (gnt_o),
    .req_out_o (req_out_o),
    .ack_in_i  (ack_in_i),
    .busy_o    (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Shared resource: ack_in_i follows req_out_o resp_delay cycles later.
  initial begin : resource
    int cnt;
    cnt = 0;
    ack_in_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        ack_in_i = 1'b0;
        cnt = 0;
      end else if (req_out_o != ack_in_i) begin
        if (cnt >= resp_delay) begin
          ack_in_i = req_out_o;
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: bench did not finish in time, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arbitration: first requester at or after p going round mod 4.
  function automatic int rr_model(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    req_i = 4'b0;
    model_ptr = 0;
    model_owner = -1;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic wait_gnt(input string nm, input logic [3:0] exp);
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (gnt_o == 4'b0 && n < 100);
    chk({nm, "_gnt"}, gnt_o, exp);
  endtask

  task automatic finish_txn(input logic [3:0] own, input string nm);
    int n;
    n = 0;
    while ((ack_o & own) == 4'b0 && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    chk({nm, "_ack"}, ack_o, own);
    req_i = req_i & ~own;
    n = 0;
    while (busy_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    chk({nm, "_idle"}, {busy_o, gnt_o, ack_o, req_out_o}, 0);
  endtask

  task automatic run_txn(input vec_t v, input string nm);
    time t0;
    int  lat;
    resp_delay = v.dly;
    @(negedge clk_i);
    req_i = v.pat;
    wait_gnt(nm, v.exp_gnt);
    t0 = $time;
    chk({nm, "_setup"}, req_out_o, 0);
    req_i = v.pat & v.exp_gnt;
    @(negedge clk_i);
    chk({nm, "_req"}, {ack_o, req_out_o}, {4'b0, 1'b1});
    finish_txn(v.exp_gnt, nm);
    lat = int'(($time - t0) / 10);
    chk({nm, "_latency"}, lat, 5 + 2 * SYNC + 2 * v.dly);
  endtask

  // 4-phase clients with random request arrivals, checked against rr_model.
  task automatic run_clients(input int ncyc, input int pct);
    logic [3:0] prev_gnt, last_req;
    int w;
    prev_gnt = gnt_o;
    last_req = req_i;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk_i);
      chk("onehot", $countones(gnt_o) <= 1, 1);
      chk("ack_owner", ack_o & ~gnt_o, 0);
      if (prev_gnt == 4'b0 && gnt_o != 4'b0) begin
        w = rr_model(last_req, model_ptr);
        chk("rr_pick", gnt_o, (w < 0) ? 0 : (1 << w));
        model_owner = w;
        gq.push_back(gnt_o);
        resp_delay = $urandom_range(0, 4);
      end else if (prev_gnt != 4'b0 && gnt_o == 4'b0 && model_owner >= 0) begin
        model_ptr = (model_owner + 1) % 4;
      end
      prev_gnt = gnt_o;
      for (int i = 0; i < 4; i++) begin
        if (req_i[i] && ack_o[i]) req_i[i] = 1'b0;
        else if (!req_i[i] && !ack_o[i] && $urandom_range(0, 99) < pct) req_i[i] = 1'b1;
      end
      last_req = req_i;
    end
  endtask

  initial begin : main
    int n, viol;
    tbl[0]  = '{4'b0001, 4'b0001, 3};
    tbl[1]  = '{4'b0001, 4'b0001, 0};
    tbl[2]  = '{4'b0110, 4'b0010, 1};
    tbl[3]  = '{4'b0011, 4'b0001, 2};
    tbl[4]  = '{4'b1000, 4'b1000, 0};
    tbl[5]  = '{4'b1010, 4'b0010, 4};
    tbl[6]  = '{4'b1001, 4'b1000, 1};
    tbl[7]  = '{4'b1111, 4'b0001, 0};
    tbl[8]  = '{4'b1100, 4'b0100, 2};
    tbl[9]  = '{4'b1001, 4'b1000, 0};
    tbl[10] = '{4'b1001, 4'b0001, 3};
    cont_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    repeat (2) @(negedge clk_i);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_ack", ack_o, 0);
    chk("rst_req_out", req_out_o, 0);
    chk("rst_busy", busy_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 11; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Contention: all four clients keep requesting.
    do_reset();
    gq.delete();
    run_clients(150, 100);
    run_clients(200, 0);
    chk("cont_count", gq.size() >= 5, 1);
    if (gq.size() >= 5)
      for (int k = 0; k < 5; k++) chk($sformatf("cont_order%0d", k), gq[k], cont_exp[k]);

    // Late arrival: client 2 raises during client 1's transaction.
    do_reset();
    resp_delay = 5;
    @(negedge clk_i);
    req_i = 4'b0010;
    wait_gnt("late1", 4'b0010);
    n = 0;
    while (!req_out_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    req_i = 4'b0110;
    viol = 0;
    n = 0;
    while (busy_o && n < 300) begin
      if (ack_o[2] || gnt_o != 4'b0010) viol++;
      if (ack_o[1]) req_i[1] = 1'b0;
      @(negedge clk_i);
      n++;
    end
    chk("late_ignored", viol, 0);
    wait_gnt("late2", 4'b0100);
    finish_txn(4'b0100, "late2");

    // Slow resource: hold REQ for a long time.
    resp_delay = 50;
    @(negedge clk_i);
    req_i = 4'b0001;
    wait_gnt("slow", 4'b0001);
    n = 0;
    while (!req_out_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    viol = 0;
    repeat (45) begin
      @(negedge clk_i);
      if (!(req_out_o && busy_o && gnt_o == 4'b0001 && ack_o == 4'b0)) viol++;
    end
    chk("slow_hold", viol, 0);
    finish_txn(4'b0001, "slow");

    // Owner withdraws its request during GNT: handshake still completes.
    resp_delay = 2;
    @(negedge clk_i);
    req_i = 4'b0001;
    wait_gnt("early", 4'b0001);
    req_i = 4'b0;
    finish_txn(4'b0001, "early");

    // Reset while in RTZ, with ptr moved away from 0 beforehand.
    do_reset();
    run_txn('{4'b0010, 4'b0010, 3}, "pre_rst");
    @(negedge clk_i);
    req_i = 4'b0100;
    wait_gnt("rtz", 4'b0100);
    n = 0;
    while (!ack_o[2] && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    req_i = 4'b0;
    n = 0;
    while (req_out_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    chk("rtz_state", {ack_o, req_out_o, busy_o}, {4'b0100, 1'b0, 1'b1});
    #1 rst_ni = 1'b0;
    #1 chk("rst_async", {ack_o, gnt_o, req_out_o, busy_o}, 0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (5) @(negedge clk_i);
    chk("rst_abandon", {busy_o, gnt_o, ack_o, req_out_o}, 0);
    req_i = 4'b1010;
    wait_gnt("rst_ptr0", 4'b0010);
    finish_txn(4'b0010, "rst_ptr0");

    // Random traffic against the reference model.
    do_reset();
    gq.delete();
    run_clients(3000, 30);
    run_clients(300, 0);
    chk("rand_drain", {busy_o, req_i}, 0);
    chk("rand_grants", gq.size() > 20, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
